// File: rtl/nios_blink_pio_button.sv
// Avalon-MM input PIO for push-buttons: 2-flop sync, optional per-bit debounce, edge capture, level irq.
// Define NIOS_BLINK_PIO_BUTTON_DEBOUNCE_EN to build the debounce counters; otherwise stable follows sync2.
module nios_blink_pio_button #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic             unused_wdata;

  // Only the low WIDTH bits of writedata reach any register.
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect && !write_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef NIOS_BLINK_PIO_BUTTON_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt [WIDTH];

  // A new level must be seen DEBOUNCE_CYCLES consecutive clocks; any return to stable restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stable <= '0;
    else       stable <= sync2;
  end
`endif

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = stable & ~stable_d;
      1:       edge_det = ~stable & stable_d;
      default: edge_det = stable ^ stable_d;
    endcase
  end

  assign cap_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Clear is applied before the OR so a same-cycle edge keeps its bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      stable_d <= stable;
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edge_cap & irq_mask);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_cap;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_blink_pio_button.sv
// Directed bench for nios_blink_pio_button (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0).
module tb_nios_blink_pio_button;

`ifdef NIOS_BLINK_PIO_BUTTON_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = '0;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  nios_blink_pio_button #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    // Reset with all buttons held
    in_port = 4'hF;
    tick(3);
    check_reg("rst_data", 2'd0, 32'h0);
    check_reg("rst_rsvd", 2'd1, 32'h0);
    check_reg("rst_mask", 2'd2, 32'h0);
    check_reg("rst_ecap", 2'd3, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    tick();
    reset = 1'b0;
    tick(LAT - 1);
    check_reg("rel_data_early", 2'd0, 32'h0);
    tick();
    check_reg("rel_data", 2'd0, 32'hF);
    tick();
    check_reg("rel_ecap", 2'd3, 32'hF);
    check("rel_irq_masked", {31'b0, irq}, 32'h0);
    wr(2'd3, 32'hF);
    check_reg("init_clear", 2'd3, 32'h0);

    // Writes to DATA and reserved are ignored
    wr(2'd0, 32'h0);
    check_reg("data_ro", 2'd0, 32'hF);
    wr(2'd1, 32'hFFFF_FFFF);
    check_reg("rsvd_ro", 2'd1, 32'h0);

    // Falling edge: latency, not captured
    in_port = 4'hE;
    tick(LAT - 1);
    check_reg("fall_early", 2'd0, 32'hF);
    tick();
    check_reg("fall_data", 2'd0, 32'hE);
    tick();
    check_reg("fall_no_cap", 2'd3, 32'h0);

    // Rising edge on bit0
    in_port = 4'hF;
    tick(LAT - 1);
    check_reg("rise_early", 2'd0, 32'hE);
    tick();
    check_reg("rise_data", 2'd0, 32'hF);
    tick();
    check_reg("rise_cap", 2'd3, 32'h1);
    wr(2'd3, 32'h1);
    check_reg("rise_clear", 2'd3, 32'h0);

    // Glitch on bit0 from a low stable level
    in_port = 4'hE;
    tick(LAT + 2);
    check_reg("glitch_pre", 2'd0, 32'hE);
`ifdef NIOS_BLINK_PIO_BUTTON_DEBOUNCE_EN
    in_port = 4'hF;
    tick(3);
    in_port = 4'hE;
    tick(10);
    check_reg("glitch_data", 2'd0, 32'hE);
    check_reg("glitch_ecap", 2'd3, 32'h0);
`else
    in_port = 4'hF;
    tick();
    in_port = 4'hE;
    tick(2);
    check_reg("glitch_seen", 2'd0, 32'hF);
    tick();
    check_reg("glitch_gone", 2'd0, 32'hE);
    check_reg("glitch_ecap", 2'd3, 32'h1);
    wr(2'd3, 32'h1);
    check_reg("glitch_clear", 2'd3, 32'h0);
`endif

    // IRQ on bit0 rising edge
    wr(2'd2, 32'h1);
    check_reg("mask_rd", 2'd2, 32'h1);
    in_port = 4'hF;
    tick(LAT);
    check("irq_before_cap", {31'b0, irq}, 32'h0);
    tick();
    check_reg("irq_cap", 2'd3, 32'h1);
    check("irq_set", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h1);
    check_reg("irq_w1c", 2'd3, 32'h0);
    check("irq_cleared", {31'b0, irq}, 32'h0);

    // Collision: W1C lands on the same edge as the capture
    in_port = 4'hE;
    tick(LAT + 2);
    check_reg("coll_pre", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(LAT);
    wr(2'd3, 32'h1);
    check_reg("coll_cap", 2'd3, 32'h1);
    check("coll_irq", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h1);
    check("coll_irq_clear", {31'b0, irq}, 32'h0);

    // Masked edge on bit2, then unmask
    wr(2'd2, 32'h0);
    in_port = 4'hB;
    tick(LAT + 2);
    check_reg("mask_pre_data", 2'd0, 32'hB);
    in_port = 4'hF;
    tick(LAT + 1);
    check_reg("mask_cap", 2'd3, 32'h4);
    check("mask_irq_off", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h4);
    check("mask_irq_on", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h1);
    check("mask_irq_other", {31'b0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
